// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage core.
//  Detects load-use, branch-compare and multi-cycle mul/div hazards. Drives stall/flush
//  for IF, ID and the ID->EX register, and operand-forwarding selects for EX and ID.
//  Owns the mul/div busy FSM and a saturating stall-cycle counter.
// Ports:
//  i_clk, i_rst_n                   clock (rising edge), async active-low reset
//  i_rs_d/i_rt_d, i_rs_e/i_rt_e     source registers in ID / EX
//  i_write_reg_e/m/w                destination register in EX / MEM / WB
//  i_reg_write_e/m/w                destination write enable per stage
//  i_mem_to_reg_e/m                 load in EX / MEM
//  i_branch_d, i_branch_taken_d     branch in ID, and its resolved direction
//  i_md_start_e, i_md_use_d         mul/div issuing in EX, ID instr needs HI/LO
//  o_stall_f, o_stall_d             hold PC / hold IF->ID register
//  o_flush_d, o_flush_e             clear IF->ID / bubble into ID->EX
//  o_forward_ae/be                  EX operand select: 00 regfile, 01 WB, 10 MEM
//  o_forward_ad/bd                  ID compare operand from MEM result
//  o_md_busy                        mul/div unit occupied
//  o_stall_count                    saturating count of cycles with StallD=1
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rs_d,
  input  logic [4:0]       i_rt_d,
  input  logic [4:0]       i_rs_e,
  input  logic [4:0]       i_rt_e,
  input  logic [4:0]       i_write_reg_e,
  input  logic [4:0]       i_write_reg_m,
  input  logic [4:0]       i_write_reg_w,
  input  logic             i_reg_write_e,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  input  logic             i_mem_to_reg_e,
  input  logic             i_mem_to_reg_m,
  input  logic             i_branch_d,
  input  logic             i_branch_taken_d,
  input  logic             i_md_start_e,
  input  logic             i_md_use_d,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic [1:0]       o_forward_ae,
  output logic [1:0]       o_forward_be,
  output logic             o_forward_ad,
  output logic             o_forward_bd,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam int unsigned CW = $clog2(MD_LATENCY);
  localparam logic [CW-1:0] CntLoad = CW'(MD_LATENCY - 1);
  localparam logic [CW-1:0] CntLast = CW'(1);

  typedef enum logic {StIdle, StBusy} md_state_e;

  md_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_md_busy;
  logic [CNT_W-1:0] r_stall_count;

  logic       w_lwstall;
  logic       w_brstall;
  logic       w_mdstall;
  logic       w_stall;
  logic [1:0] w_fwd_ae;
  logic [1:0] w_fwd_be;
  logic       w_fwd_ad;
  logic       w_fwd_bd;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic valid_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] ex_forward(input logic [4:0] src);
    if (i_reg_write_m && valid_match(i_write_reg_m, src)) begin
      return 2'b10;
    end else if (i_reg_write_w && valid_match(i_write_reg_w, src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    w_fwd_ae = ex_forward(i_rs_e);
    w_fwd_be = ex_forward(i_rt_e);
    w_fwd_ad = i_reg_write_m && valid_match(i_write_reg_m, i_rs_d);
    w_fwd_bd = i_reg_write_m && valid_match(i_write_reg_m, i_rt_d);

    w_lwstall = i_mem_to_reg_e &&
                (valid_match(i_write_reg_e, i_rs_d) || valid_match(i_write_reg_e, i_rt_d));
    // The branch compares in ID, so it must wait for a result still in EX or a load in MEM.
    w_brstall = i_branch_d &&
                ((i_reg_write_e &&
                  (valid_match(i_write_reg_e, i_rs_d) || valid_match(i_write_reg_e, i_rt_d))) ||
                 (i_mem_to_reg_m &&
                  (valid_match(i_write_reg_m, i_rs_d) || valid_match(i_write_reg_m, i_rt_d))));
    w_mdstall = i_md_use_d && (r_md_busy || i_md_start_e);
    w_stall   = i_rst_n && (w_lwstall || w_brstall || w_mdstall);
  end

  // Flush is held during reset so the unreset ID->EX register loads a bubble.
  always_comb begin
    o_stall_f    = w_stall;
    o_stall_d    = w_stall;
    o_flush_e    = !i_rst_n || w_stall;
    o_flush_d    = !i_rst_n || (i_branch_taken_d && !w_stall);
    o_forward_ae = i_rst_n ? w_fwd_ae : 2'b00;
    o_forward_be = i_rst_n ? w_fwd_be : 2'b00;
    o_forward_ad = i_rst_n && w_fwd_ad;
    o_forward_bd = i_rst_n && w_fwd_bd;
    o_md_busy    = r_md_busy;
  end

  // Busy is asserted for MD_LATENCY-1 cycles after the issue cycle. A start while busy
  // is ignored and does not reload the countdown.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_md_busy <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_md_start_e) begin
            r_state   <= StBusy;
            r_cnt     <= CntLoad;
            r_md_busy <= 1'b1;
          end
        end
        StBusy: begin
          if (r_cnt == CntLast) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state   <= StIdle;
          r_cnt     <= '0;
          r_md_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. A driver issues per-cycle stimulus (directed
// scenarios then random), computes the expected outputs from a behavioural model and
// queues them; a monitor pops and compares at each falling edge. Two DUTs share the
// inputs: default CNT_W=16, and CNT_W=4 to reach saturation.
module tb_hazard_ctrl;

  localparam int unsigned MdLat = 4;

  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic rw_e, rw_m, rw_w, mtr_e, mtr_m, br, bt, md_start, md_use, rst_n;
  } stim_t;

  typedef struct packed {
    logic stall_f, stall_d, flush_d, flush_e;
    logic [1:0] fae, fbe;
    logic fad, fbd, busy;
    logic [15:0] cnt;
    logic [3:0] cnt4;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t s = '0;

  logic        stall_f, stall_d, flush_d, flush_e, fad, fbd, busy;
  logic [1:0]  fae, fbe;
  logic [15:0] cnt;
  logic        s4_stall_f, s4_stall_d, s4_flush_d, s4_flush_e, s4_fad, s4_fbd, s4_busy;
  logic [1:0]  s4_fae, s4_fbe;
  logic [3:0]  cnt4;

  hazard_ctrl #(.MD_LATENCY(MdLat), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(s.rst_n),
    .i_rs_d(s.rs_d), .i_rt_d(s.rt_d), .i_rs_e(s.rs_e), .i_rt_e(s.rt_e),
    .i_write_reg_e(s.wr_e), .i_write_reg_m(s.wr_m), .i_write_reg_w(s.wr_w),
    .i_reg_write_e(s.rw_e), .i_reg_write_m(s.rw_m), .i_reg_write_w(s.rw_w),
    .i_mem_to_reg_e(s.mtr_e), .i_mem_to_reg_m(s.mtr_m),
    .i_branch_d(s.br), .i_branch_taken_d(s.bt),
    .i_md_start_e(s.md_start), .i_md_use_d(s.md_use),
    .o_stall_f(stall_f), .o_stall_d(stall_d), .o_flush_d(flush_d), .o_flush_e(flush_e),
    .o_forward_ae(fae), .o_forward_be(fbe), .o_forward_ad(fad), .o_forward_bd(fbd),
    .o_md_busy(busy), .o_stall_count(cnt)
  );

  hazard_ctrl #(.MD_LATENCY(MdLat), .CNT_W(4)) dut_s (
    .i_clk(clk), .i_rst_n(s.rst_n),
    .i_rs_d(s.rs_d), .i_rt_d(s.rt_d), .i_rs_e(s.rs_e), .i_rt_e(s.rt_e),
    .i_write_reg_e(s.wr_e), .i_write_reg_m(s.wr_m), .i_write_reg_w(s.wr_w),
    .i_reg_write_e(s.rw_e), .i_reg_write_m(s.rw_m), .i_reg_write_w(s.rw_w),
    .i_mem_to_reg_e(s.mtr_e), .i_mem_to_reg_m(s.mtr_m),
    .i_branch_d(s.br), .i_branch_taken_d(s.bt),
    .i_md_start_e(s.md_start), .i_md_use_d(s.md_use),
    .o_stall_f(s4_stall_f), .o_stall_d(s4_stall_d), .o_flush_d(s4_flush_d),
    .o_flush_e(s4_flush_e), .o_forward_ae(s4_fae), .o_forward_be(s4_fbe),
    .o_forward_ad(s4_fad), .o_forward_bd(s4_fbd), .o_md_busy(s4_busy),
    .o_stall_count(cnt4)
  );

  // Reference model state: remaining busy cycles and plain integer stall counters.
  int   busy_left = 0;
  int   cnt16_m   = 0;
  int   cnt4_m    = 0;
  logic last_stall = 1'b0;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  function automatic bit dep(input logic [4:0] dst, input logic [4:0] src);
    return dst != 0 && dst == src;
  endfunction

  function automatic exp_t model(input stim_t x);
    exp_t e;
    bit lw, brh, md, st;
    e = '0;
    if (!x.rst_n) begin
      e.flush_d = 1'b1;
      e.flush_e = 1'b1;
      return e;
    end
    lw  = x.mtr_e && (dep(x.wr_e, x.rs_d) || dep(x.wr_e, x.rt_d));
    brh = x.br && ((x.rw_e && (dep(x.wr_e, x.rs_d) || dep(x.wr_e, x.rt_d))) ||
                   (x.mtr_m && (dep(x.wr_m, x.rs_d) || dep(x.wr_m, x.rt_d))));
    md  = x.md_use && (busy_left > 0 || x.md_start);
    st  = lw || brh || md;
    e.stall_f = st;
    e.stall_d = st;
    e.flush_e = st;
    e.flush_d = x.bt && !st;
    e.fae = (x.rw_m && dep(x.wr_m, x.rs_e)) ? 2'd2 : (x.rw_w && dep(x.wr_w, x.rs_e)) ? 2'd1 : 2'd0;
    e.fbe = (x.rw_m && dep(x.wr_m, x.rt_e)) ? 2'd2 : (x.rw_w && dep(x.wr_w, x.rt_e)) ? 2'd1 : 2'd0;
    e.fad = x.rw_m && dep(x.wr_m, x.rs_d);
    e.fbd = x.rw_m && dep(x.wr_m, x.rt_d);
    e.busy = busy_left > 0;
    e.cnt  = 16'(cnt16_m);
    e.cnt4 = 4'(cnt4_m);
    return e;
  endfunction

  // Advance the model across a rising edge, then apply the next cycle's stimulus.
  task automatic step(input stim_t ns);
    exp_t e;
    @(posedge clk);
    if (s.rst_n) begin
      if (last_stall) begin
        if (cnt16_m < 65535) cnt16_m++;
        if (cnt4_m < 15) cnt4_m++;
      end
      if (busy_left > 0) busy_left--;
      else if (s.md_start) busy_left = MdLat - 1;
    end
    #1;
    s = ns;
    if (!ns.rst_n) begin
      busy_left = 0;
      cnt16_m   = 0;
      cnt4_m    = 0;
    end
    e = model(ns);
    last_stall = e.stall_d;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares whatever the driver has queued for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_f", 16'(stall_f), 16'(e.stall_f));
        chk("stall_d", 16'(stall_d), 16'(e.stall_d));
        chk("flush_d", 16'(flush_d), 16'(e.flush_d));
        chk("flush_e", 16'(flush_e), 16'(e.flush_e));
        chk("forward_ae", 16'(fae), 16'(e.fae));
        chk("forward_be", 16'(fbe), 16'(e.fbe));
        chk("forward_ad", 16'(fad), 16'(e.fad));
        chk("forward_bd", 16'(fbd), 16'(e.fbd));
        chk("md_busy", 16'(busy), 16'(e.busy));
        chk("stall_count", cnt, e.cnt);
        chk("stall_count_w4", 16'(cnt4), 16'(e.cnt4));
        chk("stall_d_w4", 16'(s4_stall_d), 16'(e.stall_d));
      end
    end
  end

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  function automatic stim_t rand_stim();
    stim_t x;
    x.rs_d = rreg(); x.rt_d = rreg(); x.rs_e = rreg(); x.rt_e = rreg();
    x.wr_e = rreg(); x.wr_m = rreg(); x.wr_w = rreg();
    x.rw_e = 1'($urandom_range(0, 1));
    x.rw_m = 1'($urandom_range(0, 1));
    x.rw_w = 1'($urandom_range(0, 1));
    x.mtr_e = ($urandom_range(0, 3) == 0);
    x.mtr_m = ($urandom_range(0, 3) == 0);
    x.br = ($urandom_range(0, 2) == 0);
    x.bt = x.br && ($urandom_range(0, 1) == 1);
    x.md_start = ($urandom_range(0, 7) == 0);
    x.md_use = ($urandom_range(0, 3) == 0);
    x.rst_n = ($urandom_range(0, 299) != 0);
    return x;
  endfunction

  initial begin
    stim_t v;
    s = '0;
    // Reset, then idle.
    v = '0;
    repeat (3) step(v);
    v.rst_n = 1'b1;
    repeat (2) step(v);
    // Forwarding: MEM wins, then WB, then register 0 never forwards.
    v.wr_m = 5'd5; v.wr_w = 5'd5; v.rw_m = 1'b1; v.rw_w = 1'b1; v.rs_e = 5'd5; v.rt_e = 5'd5;
    step(v);
    v.rw_m = 1'b0;
    step(v);
    v.rs_e = 5'd0;
    step(v);
    v = '0; v.rst_n = 1'b1;
    // Load-use on Rt_D, then destination 0.
    v.mtr_e = 1'b1; v.wr_e = 5'd8; v.rt_d = 5'd8;
    step(v);
    v.wr_e = 5'd0;
    step(v);
    v = '0; v.rst_n = 1'b1;
    // Branch waits on an EX result, then resolves taken.
    v.br = 1'b1; v.bt = 1'b1; v.rw_e = 1'b1; v.wr_e = 5'd3; v.rs_d = 5'd3;
    step(v);
    v.rw_e = 1'b0;
    step(v);
    v = '0; v.rst_n = 1'b1;
    // Mul/div issue with a dependent instruction held in ID.
    v.md_start = 1'b1; v.md_use = 1'b1;
    step(v);
    v.md_start = 1'b0;
    repeat (5) step(v);
    // Reset in the middle of BUSY.
    v = '0; v.rst_n = 1'b1; v.md_start = 1'b1;
    step(v);
    v.md_start = 1'b0;
    step(v);
    v.rst_n = 1'b0;
    step(v);
    v.rst_n = 1'b1;
    repeat (2) step(v);
    // Hold a load-use hazard long enough to saturate the 4-bit counter.
    v.mtr_e = 1'b1; v.wr_e = 5'd9; v.rs_d = 5'd9;
    repeat (20) step(v);
    v = '0; v.rst_n = 1'b1;
    step(v);
    // Random traffic.
    for (int i = 0; i < 3000; i++) step(rand_stim());
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
